// File: rtl/apb_periph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_periph_pkg                                                   |
// | Purpose  : Shared types and constants for the APB peripheral hub.          |
// |            hub_state_e  - hub FSM state encoding                           |
// |            idx_width()  - width of a slave index, at least one bit         |
// |            TimeoutErrData - PRDATA returned on a timed-out transfer        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package apb_periph_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } hub_state_e;

  // Wide enough for any practical data bus; users truncate to DataWidth.
  localparam int unsigned MaxDataWidth = 256;
  localparam logic [MaxDataWidth-1:0] TimeoutErrData = '0;

  // A single slave still needs a one-bit index vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_timeout_cnt                                                  |
// | Purpose  : Counts downstream ACCESS cycles; flags expiry on the last one.  |
// | Ports    : clk_i, rst_ni   - clock, async active-low reset                 |
// |            clear_i         - return count to zero                          |
// |            en_i            - count this cycle                              |
// |            expired_o       - enabled and count == TimeoutCycles-1          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_timeout_cnt
  import apb_periph_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The hub leaves ACCESS on expiry, so the count never wraps.
  assign expired_o = en_i && (cnt_q == CntWidth'(TimeoutCycles - 1));

endmodule
`default_nettype wire

// File: rtl/apb_periph_hub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_periph_hub                                                   |
// | Purpose  : One APB master to NrPeriphs APB slaves in equal 2^WinBits      |
// |            windows from BaseAddr. Out-of-map accesses and slave timeouts  |
// |            answer with PSLVERR; error responses bump a saturating counter.|
// | Ports    : s_*  - upstream APB slave port (from the SoC master)           |
// |            m_*  - downstream APB master port, one-hot PSEL, shared rest   |
// |            err_count_o - saturating count of error responses             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_periph_hub
  import apb_periph_pkg::*;
#(
  parameter int unsigned NrPeriphs     = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = 32'hC000_0000,
  parameter int unsigned WinBits       = 12,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned ErrCntWidth   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           s_psel_i,
  input  logic                           s_penable_i,
  input  logic                           s_pwrite_i,
  input  logic [AddrWidth-1:0]           s_paddr_i,
  input  logic [DataWidth-1:0]           s_pwdata_i,
  output logic [DataWidth-1:0]           s_prdata_o,
  output logic                           s_pready_o,
  output logic                           s_pslverr_o,
  output logic [NrPeriphs-1:0]           m_psel_o,
  output logic                           m_penable_o,
  output logic                           m_pwrite_o,
  output logic [AddrWidth-1:0]           m_paddr_o,
  output logic [DataWidth-1:0]           m_pwdata_o,
  input  logic [NrPeriphs*DataWidth-1:0] m_prdata_i,
  input  logic [NrPeriphs-1:0]           m_pready_i,
  input  logic [NrPeriphs-1:0]           m_pslverr_i,
  output logic [ErrCntWidth-1:0]         err_count_o
);

  localparam int unsigned IdxWidth = idx_width(NrPeriphs);

  hub_state_e             state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   slverr_q, slverr_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

  logic [AddrWidth-1:0]   off;
  logic                   out_of_map;
  logic                   err_event;
  logic                   expired;
  logic                   in_xfer;
  logic [DataWidth-1:0]   prdata_arr [NrPeriphs];

  for (genvar i = 0; i < NrPeriphs; i++) begin : g_unpack
    assign prdata_arr[i] = m_prdata_i[i*DataWidth +: DataWidth];
  end

  // Addresses below BaseAddr wrap to a huge offset, but the explicit compare
  // keeps the intent obvious.
  assign off        = s_paddr_i - BaseAddr;
  assign out_of_map = (s_paddr_i < BaseAddr) ||
                      ((off >> WinBits) >= AddrWidth'(NrPeriphs));

  apb_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q != ACCESS),
    .en_i     (state_q == ACCESS),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    err_event = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_psel_i && !s_penable_i) begin
          if (out_of_map) begin
            state_d   = ERR;
            err_event = 1'b1;
          end else begin
            state_d = SETUP;
            addr_d  = s_paddr_i;
            wdata_d = s_pwdata_i;
            write_d = s_pwrite_i;
            idx_d   = IdxWidth'(off >> WinBits);
          end
        end
      end
      ERR:   state_d = IDLE;
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A ready slave wins over a simultaneous expiry.
        if (m_pready_i[idx_q]) begin
          state_d   = RESP;
          rdata_d   = prdata_arr[idx_q];
          slverr_d  = m_pslverr_i[idx_q];
          err_event = m_pslverr_i[idx_q];
        end else if (expired) begin
          state_d   = RESP;
          rdata_d   = DataWidth'(TimeoutErrData);
          slverr_d  = 1'b1;
          err_event = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs decode only registered state, so they are glitch-free relative to
  // the upstream inputs and all fall to zero the moment reset asserts.
  assign in_xfer     = (state_q == SETUP) || (state_q == ACCESS);
  assign m_psel_o    = in_xfer ? (NrPeriphs'(1) << idx_q) : '0;
  assign m_penable_o = (state_q == ACCESS);
  assign m_pwrite_o  = in_xfer && write_q;
  assign m_paddr_o   = in_xfer ? addr_q  : '0;
  assign m_pwdata_o  = in_xfer ? wdata_q : '0;

  assign s_pready_o  = (state_q == ERR) || (state_q == RESP);
  assign s_pslverr_o = (state_q == ERR) || ((state_q == RESP) && slverr_q);
  assign s_prdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign err_count_o = err_cnt_q;

endmodule
`default_nettype wire
